// File: rtl/test_stream_checker_pkg.sv
// Shared constants for the stream checker: FSM encoding, LFSR geometry, counter widths.
package test_stream_checker_pkg;

  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned ERR_CNT_W = 16;
  localparam int unsigned CYC_W     = 32;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/test_stream_checker_if.sv
// Multi-channel val/rdy stream bundle; channel c occupies msg[c*W +: W].
interface test_stream_checker_if #(
  parameter int unsigned NCH = 1,
  parameter int unsigned W   = 32
);
  logic [NCH-1:0]   val;
  logic [NCH*W-1:0] msg;
  logic [NCH-1:0]   rdy;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/test_stream_checker_fifo.sv
// Synchronous FIFO holding expected messages; head is registered storage, no bypass.
module test_stream_checker_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/test_stream_checker.sv
// Multi-channel val/rdy bench sink: in-order compare against queued expectations,
// LFSR backpressure, mismatch accounting and a RUN-cycle watchdog.
module test_stream_checker
  import test_stream_checker_pkg::*;
#(
  parameter int unsigned NCH          = 1,
  parameter int unsigned W            = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned TIMEOUT      = 10000,
  parameter int unsigned STALL_THRESH = 0,
  parameter logic [15:0] SEED         = 16'hBEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  test_stream_checker_if.slave  exp_if,
  test_stream_checker_if.slave  in_if,
  output logic                  done,
  output logic                  timeout,
  output logic                  err,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [$clog2(NCH):0]  err_ch,
  output logic [CYC_W-1:0]      cycles
);
  localparam int unsigned CHW  = $clog2(NCH) + 1;
  localparam int unsigned CNTW = $clog2(DEPTH) + 1;

  logic [1:0]           state_q, state_d;
  logic [CYC_W-1:0]     cycles_q, cycles_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [CHW-1:0]       err_ch_q, err_ch_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;

  logic                 running;
  logic [NCH-1:0]       exp_rdy_v, in_rdy_v, mism, drained;

  assign running = (state_q == ST_RUN);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic              full, empty, stall, push, pop;
    logic [W-1:0]      head;
    logic [CNTW-1:0]   count;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    assign push         = exp_if.val[c] & ~full;
    assign exp_rdy_v[c] = ~full;
    assign in_rdy_v[c]  = running & ~empty & ~stall;
    assign pop          = in_if.val[c] & in_rdy_v[c];
    // Case inequality so X/Z on the DUT side registers as a mismatch.
    assign mism[c]      = pop && (in_if.msg[c*W +: W] !== head);
    // FIFO will be empty after this cycle's pop.
    assign drained[c]   = (count == CNTW'(pop));

    test_stream_checker_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (exp_if.msg[c*W +: W]),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (head),
      .count (count)
    );

    always_comb begin
      lfsr_d = lfsr_q;
      if (running) lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk) begin
      if (rst) lfsr_q <= SEED ^ LFSR_W'(c + 1);
      else     lfsr_q <= lfsr_d;
    end

    if (STALL_THRESH == 0) begin : g_nostall
      assign stall = 1'b0;
    end else begin : g_stall
      assign stall = (lfsr_q[3:0] < 4'(STALL_THRESH));
    end
  end

  assign exp_if.rdy = exp_rdy_v;
  assign in_if.rdy  = in_rdy_v;

  always_comb begin
    int unsigned mism_n;
    logic [CHW-1:0] first_ch;
    logic [31:0]    err_sum;

    state_d     = state_q;
    cycles_d    = cycles_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    err_ch_d    = err_ch_q;
    mism_n      = 0;
    first_ch    = '0;
    err_sum     = '0;

    // Descending scan leaves the lowest mismatching channel in first_ch.
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (mism[i]) begin
        mism_n   = mism_n + 1;
        first_ch = CHW'(i);
      end
    end

    if (mism_n != 0) begin
      err_d   = 1'b1;
      err_sum = 32'(err_count_q) + mism_n;
      err_count_d = (err_sum > 32'hFFFF) ? '1 : ERR_CNT_W'(err_sum);
      if (!err_q) err_ch_d = first_ch;
    end

    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (cycles_q != '1) cycles_d = cycles_q + CYC_W'(1);
        if ((&drained) && (exp_if.val == '0)) state_d = ST_DONE;
        else if (cycles_d == CYC_W'(TIMEOUT))  state_d = ST_TIMEOUT;
      end
      default: state_d = state_q;
    endcase

    done_d    = (state_d == ST_DONE);
    timeout_d = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cycles_q    <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      err_ch_q    <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      err_ch_q    <= err_ch_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign done      = done_q;
  assign timeout   = timeout_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign err_ch    = err_ch_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_test_stream_checker.sv
// Bench for test_stream_checker: random traffic compared against a queue-based reference model.
module tb_test_stream_checker;
  localparam int unsigned NCH    = 2;
  localparam int unsigned W      = 8;
  localparam int unsigned MW     = NCH * W;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TMO    = 40;
  localparam int unsigned THRESH = 8;

  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2, S_TMO = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic        done, timeout, err;
  logic [15:0] err_count;
  logic [1:0]  err_ch;
  logic [31:0] cycles;

  always #5 clk = ~clk;

  test_stream_checker_if #(.NCH(NCH), .W(W)) exp_if ();
  test_stream_checker_if #(.NCH(NCH), .W(W)) in_if ();

  test_stream_checker #(
    .NCH(NCH), .W(W), .DEPTH(DEPTH), .TIMEOUT(TMO),
    .STALL_THRESH(THRESH), .SEED(16'hBEEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .exp_if    (exp_if),
    .in_if     (in_if),
    .done      (done),
    .timeout   (timeout),
    .err       (err),
    .err_count (err_count),
    .err_ch    (err_ch),
    .cycles    (cycles)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // Reference model state
  int          m_state;
  logic [W-1:0] mq [NCH][$];
  logic [15:0] m_lfsr [NCH];
  logic [31:0] m_cycles;
  logic        m_err;
  logic [15:0] m_errcnt;
  logic [1:0]  m_errch;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_lfsr[c] = 16'hBEEF ^ 16'(c + 1);
    end
    m_state  = S_IDLE;
    m_cycles = 0;
    m_err    = 1'b0;
    m_errcnt = 0;
    m_errch  = 0;
  endtask

  // Check outputs against the model, advance the model with the driven inputs, clock once.
  task automatic step();
    logic [NCH-1:0] rdy_e, erdy_e;
    int nmis, first, tot;
    bit all_empty;
    for (int c = 0; c < NCH; c++) begin
      rdy_e[c]  = (m_state == S_RUN) && (mq[c].size() > 0) && !(m_lfsr[c][3:0] < 4'(THRESH));
      erdy_e[c] = (mq[c].size() < DEPTH);
    end
    check("in_rdy",    32'(in_if.rdy),  32'(rdy_e));
    check("exp_rdy",   32'(exp_if.rdy), 32'(erdy_e));
    check("done",      32'(done),       32'(m_state == S_DONE));
    check("timeout",   32'(timeout),    32'(m_state == S_TMO));
    check("err",       32'(err),        32'(m_err));
    check("err_count", 32'(err_count),  32'(m_errcnt));
    check("err_ch",    32'(err_ch),     32'(m_errch));
    check("cycles",    cycles,          m_cycles);

    if (rst) begin
      model_reset();
    end else begin
      nmis = 0;
      first = -1;
      for (int c = 0; c < NCH; c++) begin
        if (in_if.val[c] && rdy_e[c]) begin
          if (in_if.msg[c*W +: W] !== mq[c][0]) begin
            nmis++;
            if (first < 0) first = c;
          end
          void'(mq[c].pop_front());
        end
      end
      for (int c = 0; c < NCH; c++)
        if (exp_if.val[c] && erdy_e[c]) mq[c].push_back(exp_if.msg[c*W +: W]);
      if (nmis > 0) begin
        if (!m_err) m_errch = 2'(first);
        m_err = 1'b1;
        tot = int'(m_errcnt) + nmis;
        m_errcnt = (tot > 65535) ? 16'hFFFF : 16'(tot);
      end
      if (m_state == S_IDLE) begin
        if (start) m_state = S_RUN;
      end else if (m_state == S_RUN) begin
        if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
        for (int c = 0; c < NCH; c++) m_lfsr[c] = lfsr_step(m_lfsr[c]);
        all_empty = 1'b1;
        for (int c = 0; c < NCH; c++) if (mq[c].size() != 0) all_empty = 1'b0;
        if (all_empty && exp_if.val == '0) m_state = S_DONE;
        else if (m_cycles == TMO)          m_state = S_TMO;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    exp_if.val = '0;
    exp_if.msg = '0;
    in_if.val  = '0;
    in_if.msg  = '0;
    start      = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drive_in(input int val_pct, input int bad_pct);
    for (int c = 0; c < NCH; c++) begin
      in_if.val[c] = ($urandom_range(99) < val_pct);
      if (mq[c].size() > 0 && $urandom_range(99) >= bad_pct) in_if.msg[c*W +: W] = mq[c][0];
      else                                                    in_if.msg[c*W +: W] = W'($urandom);
    end
  endtask

  task automatic run_once(input int fill_n, input int val_pct, input int bad_pct,
                          input int run_len, input bit run_push);
    do_reset();
    for (int i = 0; i < fill_n; i++) begin
      exp_if.val = NCH'($urandom);
      exp_if.msg = MW'($urandom);
      step();
    end
    exp_if.val = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < run_len; i++) begin
      drive_in(val_pct, bad_pct);
      exp_if.val = run_push ? NCH'($urandom & $urandom & $urandom) : '0;
      exp_if.msg = MW'($urandom);
      step();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    check("rst_exp_rdy", 32'(exp_if.rdy), 32'd3);
    check("rst_in_rdy",  32'(in_if.rdy),  32'd0);
    check("rst_cycles",  cycles,          32'd0);

    // Fill both channels past full: exp_rdy must drop
    for (int i = 0; i < 6; i++) begin
      exp_if.val = 2'b11;
      exp_if.msg = MW'($urandom);
      step();
    end
    exp_if.val = '0;
    check("full_exp_rdy", 32'(exp_if.rdy), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 36; i++) begin
      drive_in(100, 0);
      step();
    end
    drive_idle();
    check("drain_err", 32'(err), 32'd0);

    for (int r = 0; r < 30; r++)
      run_once($urandom_range(10), $urandom_range(30, 100), $urandom_range(0, 60),
               $urandom_range(5, 50), 1'($urandom_range(1)));

    // Watchdog: one pending entry, DUT never valid
    do_reset();
    exp_if.val = 2'b01;
    exp_if.msg = 16'h00A5;
    step();
    exp_if.val = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (TMO + 5) step();
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_cycles",  cycles,       32'(TMO));
    check("to_done",    32'(done),    32'd0);

    // Reset mid-RUN with entries pending and errors logged
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_if.val = 2'b01;
      exp_if.msg = MW'(8'h10 + i);
      step();
    end
    exp_if.val = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_if.val = 2'b01;
      in_if.msg = 16'h00FF;
      step();
    end
    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_exp_rdy",   32'(exp_if.rdy), 32'd3);
    check("mid_in_rdy",    32'(in_if.rdy),  32'd0);
    check("mid_err_count", 32'(err_count),  32'd0);
    check("mid_done",      32'(done),       32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
